// File: rtl/gray_rx_if.sv
// Bus between the gray encoder stage and its downstream checker: the gray code and error clear go
// in, the decoded value and status come back.
interface gray_rx_if #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     gray_in;
    logic                 clr_err;
    logic [WIDTH-1:0]     bin_out;
    logic                 bin_valid;
    logic                 locked;
    logic                 step_up;
    logic                 step_down;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output gray_in, clr_err,
        input  bin_out, bin_valid, locked, step_up, step_down, err_pulse, err_count
    );

    modport slave (
        input  gray_in, clr_err,
        output bin_out, bin_valid, locked, step_up, step_down, err_pulse, err_count
    );
endinterface

// File: rtl/gray_rx_checker.sv
// Synchronises a gray-coded bus, converts it to binary and checks that each change is a single
// +1/-1 step; illegal changes are counted and force re-acquisition.
module gray_rx_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CYCLES = 3,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic     clk,
    input  logic     rst,
    gray_rx_if.slave rx
);
    localparam int unsigned CntW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CntW-1:0] LockLast = CntW'(LOCK_CYCLES - 1);

    typedef enum logic {StAcquire, StLocked} state_e;

    state_e               r_state, w_state_next;
    logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]     r_prev;
    logic [WIDTH-1:0]     r_bin_out, w_bin_out_next;
    logic [CntW-1:0]      r_stab_cnt, w_stab_cnt_next;
    logic                 r_step_up, r_step_down, r_err_pulse;
    logic                 w_up, w_down, w_err;
    logic [ERR_CNT_W-1:0] r_err_count, w_err_count_next;
    logic [WIDTH-1:0]     w_sync, w_bin_sync, w_bin_prev, w_diff;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_bin_sync = gray2bin(w_sync);
    assign w_bin_prev = gray2bin(r_prev);
    // Modular difference: 1 is an up step, all-ones is a down step (wrap included).
    assign w_diff     = w_bin_sync - w_bin_prev;

    always_comb begin
        w_state_next    = r_state;
        w_bin_out_next  = r_bin_out;
        w_stab_cnt_next = r_stab_cnt;
        w_up            = 1'b0;
        w_down          = 1'b0;
        w_err           = 1'b0;
        unique case (r_state)
            StAcquire: begin
                if (w_sync != r_prev) begin
                    w_stab_cnt_next = '0;
                end else if (r_stab_cnt == LockLast) begin
                    w_state_next    = StLocked;
                    w_bin_out_next  = w_bin_sync;
                    w_stab_cnt_next = '0;
                end else begin
                    w_stab_cnt_next = r_stab_cnt + CntW'(1);
                end
            end
            StLocked: begin
                if (w_sync == r_prev) begin
                    w_bin_out_next = r_bin_out;
                end else if (w_diff == WIDTH'(1)) begin
                    w_bin_out_next = w_bin_sync;
                    w_up           = 1'b1;
                end else if (w_diff == '1) begin
                    w_bin_out_next = w_bin_sync;
                    w_down         = 1'b1;
                end else begin
                    w_err           = 1'b1;
                    w_state_next    = StAcquire;
                    w_stab_cnt_next = '0;
                end
            end
            default: w_state_next = StAcquire;
        endcase
    end

    always_comb begin
        w_err_count_next = r_err_count;
        if (rx.clr_err) begin
            w_err_count_next = w_err ? ERR_CNT_W'(1) : '0;
        end else if (w_err && (r_err_count != '1)) begin
            w_err_count_next = r_err_count + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_prev      <= '0;
            r_state     <= StAcquire;
            r_bin_out   <= '0;
            r_stab_cnt  <= '0;
            r_step_up   <= 1'b0;
            r_step_down <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_sync[0] <= rx.gray_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev      <= w_sync;
            r_state     <= w_state_next;
            r_bin_out   <= w_bin_out_next;
            r_stab_cnt  <= w_stab_cnt_next;
            r_step_up   <= w_up;
            r_step_down <= w_down;
            r_err_pulse <= w_err;
            r_err_count <= w_err_count_next;
        end
    end

    assign rx.bin_out   = r_bin_out;
    assign rx.locked    = (r_state == StLocked);
    assign rx.bin_valid = (r_state == StLocked);
    assign rx.step_up   = r_step_up;
    assign rx.step_down = r_step_down;
    assign rx.err_pulse = r_err_pulse;
    assign rx.err_count = r_err_count;
endmodule

// File: tb/tb_gray_rx_checker.sv
// Bench for gray_rx_checker: directed vectors and sequences plus random traffic against a
// cycle-level reference model; a second instance with a 2-bit error counter checks saturation.
module tb_gray_rx_checker;
    localparam int unsigned W  = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned LC = 3;
    localparam int N = 1 << W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_rx_if #(.WIDTH(W), .ERR_CNT_W(8)) rx ();
    gray_rx_if #(.WIDTH(W), .ERR_CNT_W(2)) rx2 ();

    assign rx2.gray_in = rx.gray_in;
    assign rx2.clr_err = rx.clr_err;

    gray_rx_checker #(.WIDTH(W), .SYNC_STAGES(SS), .LOCK_CYCLES(LC), .ERR_CNT_W(8)) u_dut (
        .clk(clk),
        .rst(rst),
        .rx (rx)
    );

    gray_rx_checker #(.WIDTH(W), .SYNC_STAGES(SS), .LOCK_CYCLES(LC), .ERR_CNT_W(2)) u_dut2 (
        .clk(clk),
        .rst(rst),
        .rx (rx2)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int m_q[$];
    int m_prev, m_bin, m_run, m_ec8, m_ec2;
    bit m_locked, m_up, m_down, m_err;

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse found by search rather than by the XOR recurrence.
    function automatic int g2b(input int g);
        for (int b = 0; b < N; b++) begin
            if (b2g(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < int'(SS); i++) m_q.push_back(0);
        m_prev = 0; m_bin = 0; m_run = 0; m_ec8 = 0; m_ec2 = 0;
        m_locked = 0; m_up = 0; m_down = 0; m_err = 0;
    endtask

    task automatic model_edge(input int g, input bit clr);
        int s;
        int d;
        s = m_q[SS-1];
        m_up = 0; m_down = 0; m_err = 0;
        if (!m_locked) begin
            if (s == m_prev) begin
                m_run++;
                if (m_run == int'(LC)) begin
                    m_locked = 1; m_bin = g2b(s); m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (s != m_prev) begin
            d = (g2b(s) - g2b(m_prev) + N) % N;
            if (d == 1) begin
                m_up = 1; m_bin = g2b(s);
            end else if (d == N - 1) begin
                m_down = 1; m_bin = g2b(s);
            end else begin
                m_err = 1; m_locked = 0; m_run = 0;
            end
        end
        if (clr) begin
            m_ec8 = m_err ? 1 : 0;
            m_ec2 = m_err ? 1 : 0;
        end else if (m_err) begin
            if (m_ec8 < 255) m_ec8++;
            if (m_ec2 < 3) m_ec2++;
        end
        m_prev = s;
        m_q.push_front(g);
        void'(m_q.pop_back());
    endtask

    // Drive inputs (we sit 1 ns after an edge), clock once, then compare against the model.
    task automatic cycle(input int g, input bit c);
        logic [31:0] got, exp;
        rx.gray_in = W'(g);
        rx.clr_err = c;
        @(posedge clk);
        model_edge(g, c);
        #1;
        got = 32'({rx.err_count, rx.err_pulse, rx.step_down, rx.step_up, rx.locked,
                   rx.bin_valid, rx.bin_out});
        exp = 32'({8'(m_ec8), m_err, m_down, m_up, m_locked, m_locked, 4'(m_bin)});
        check("model_outputs", got, exp);
        check("model_errcnt2", 32'(rx2.err_count), 32'(m_ec2));
    endtask

    typedef struct {
        int g0;
        int g1;
        int kind; // 0 hold, 1 up, 2 down, 3 error
        int bout;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ups;
        int cur, nxt, rb, r, ec_before;
        tbl[0]  = '{4'b0000, 4'b0001, 1, 1};
        tbl[1]  = '{4'b0001, 4'b0000, 2, 0};
        tbl[2]  = '{4'b1000, 4'b0000, 1, 0};
        tbl[3]  = '{4'b0000, 4'b1000, 2, 15};
        tbl[4]  = '{4'b0001, 4'b1001, 3, 1};
        tbl[5]  = '{4'b0000, 4'b0011, 3, 0};
        tbl[6]  = '{4'b0111, 4'b0110, 2, 4};
        tbl[7]  = '{4'b0110, 4'b0010, 2, 3};
        tbl[8]  = '{4'b0010, 4'b0110, 1, 4};
        tbl[9]  = '{4'b1101, 4'b1100, 2, 8};
        tbl[10] = '{4'b1101, 4'b1111, 1, 10};
        tbl[11] = '{4'b0101, 4'b0101, 0, 6};

        rx.gray_in = '0;
        rx.clr_err = 1'b0;
        model_reset();
        #12;
        check("reset_state", 32'({rx.err_count, rx.err_pulse, rx.step_down, rx.step_up,
                                  rx.locked, rx.bin_valid, rx.bin_out}), 32'd0);
        rst = 1'b0;

        // Lock from reset with constant zero input: locked after the third edge.
        cycle(0, 0);
        cycle(0, 0);
        check("unlocked_edge2", 32'(rx.locked), 32'd0);
        cycle(0, 0);
        check("locked_edge3", 32'({rx.locked, rx.bin_valid}), 32'd3);
        check("lock_bin0", 32'(rx.bin_out), 32'd0);

        // Upward walk 1..15,0 one code per 4 cycles.
        ups = 0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < 4; j++) begin
                cycle(b2g(k % N), 0);
                ups += int'(rx.step_up);
            end
            check("walk_bin", 32'(rx.bin_out), 32'(k % N));
        end
        check("walk_up_count", 32'(ups), 32'(N));
        check("walk_errcnt", 32'(rx.err_count), 32'd0);

        // Single-transition vectors.
        foreach (tbl[i]) begin
            repeat (8) cycle(tbl[i].g0, 0);
            check("vec_locked_before", 32'(rx.locked), 32'd1);
            repeat (3) cycle(tbl[i].g1, 0);
            check("vec_pulse", 32'({rx.err_pulse, rx.step_down, rx.step_up}),
                  (tbl[i].kind == 0) ? 32'd0 : 32'd1 << (tbl[i].kind - 1));
            check("vec_bin", 32'(rx.bin_out), 32'(tbl[i].bout));
        end

        // Non-adjacent single-bit change, then relock on the new code.
        repeat (8) cycle(4'b0001, 0);
        ec_before = m_ec8;
        repeat (3) cycle(4'b1001, 0);
        check("jump_err", 32'({rx.err_pulse, rx.locked}), 32'd2);
        check("jump_bin_hold", 32'(rx.bin_out), 32'd1);
        check("jump_errcnt", 32'(rx.err_count), 32'(ec_before + 1));
        repeat (2) cycle(4'b1001, 0);
        check("relock_not_yet", 32'(rx.locked), 32'd0);
        cycle(4'b1001, 0);
        check("relock", 32'(rx.locked), 32'd1);
        check("relock_bin", 32'(rx.bin_out), 32'd14);

        // Saturation on the 2-bit counter, then clear coincident with an error.
        repeat (8) cycle(0, 0);
        cycle(0, 1);
        check("clr_alone", 32'({rx2.err_count, rx.err_count}), 32'd0);
        cur = 0;
        for (int i = 0; i < 5; i++) begin
            nxt = (cur == 0) ? 4'b0011 : 0;
            repeat (3) cycle(nxt, 0);
            check("sat_err_pulse", 32'(rx.err_pulse), 32'd1);
            repeat (6) cycle(nxt, 0);
            cur = nxt;
        end
        check("sat_cnt2", 32'(rx2.err_count), 32'd3);
        check("sat_cnt8", 32'(rx.err_count), 32'd5);
        nxt = (cur == 0) ? 4'b0011 : 0;
        repeat (2) cycle(nxt, 0);
        cycle(nxt, 1);
        check("clr_with_err_pulse", 32'(rx2.err_pulse), 32'd1);
        check("clr_with_err_cnt2", 32'(rx2.err_count), 32'd1);
        check("clr_with_err_cnt8", 32'(rx.err_count), 32'd1);

        // Asynchronous reset while locked at 9, relock with 1101 held.
        repeat (8) cycle(4'b1101, 0);
        check("pre_reset_bin", 32'({rx.locked, rx.bin_out}), 32'h19);
        #2 rst = 1'b1;
        #1;
        check("async_reset", 32'({rx.err_count, rx.err_pulse, rx.step_down, rx.step_up,
                                  rx.locked, rx.bin_valid, rx.bin_out}), 32'd0);
        check("async_reset2", 32'({rx2.err_count, rx2.locked, rx2.bin_out}), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        repeat (5) cycle(4'b1101, 0);
        check("post_reset_unlocked", 32'(rx.locked), 32'd0);
        cycle(4'b1101, 0);
        check("post_reset_lock", 32'({rx.locked, rx.bin_out}), 32'h19);

        // Random traffic: holds, legal steps (often back to back), occasional jumps and clears.
        rb = 9;
        for (int n = 0; n < 2000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) rb = rb;
            else if (r < 65) rb = (rb + 1) % N;
            else if (r < 90) rb = (rb + N - 1) % N;
            else rb = int'($urandom_range(0, N - 1));
            cycle(b2g(rb), ($urandom_range(0, 31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
